sram_arbiter_ctrl: RTL and testbench

Multi-port controller for the external asynchronous SRAM (19-bit address, 8-bit data, single active-low write enable). It arbitrates NPORTS internal requesters, such as the video fetcher and the CPU, onto one SRAM bus. It generates glitch-free write cycles with a configurable number of wait states. It sits between the core and the top-level SRAM pins and replaces direct combinational drive of sram_addr, sram_data and sram_we_n.

---
 rtl/sram_arbiter_ctrl_if.sv | 25 ++
 rtl/sram_arbiter_ctrl.sv | 144 ++++++++++++++
 tb/tb_sram_arbiter_ctrl.sv | 446 ++++++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/sram_arbiter_ctrl_if.sv
// Requester-side bundle of the SRAM arbiter: per-port request
// inputs and the arbiter's ack / read-data / busy returns.
interface sram_arbiter_ctrl_if #(
  parameter int NPORTS = 2,
  parameter int AW     = 19,
  parameter int DW     = 8
);
  logic [NPORTS-1:0]    req;
  logic [NPORTS-1:0]    we;
  logic [NPORTS*AW-1:0] addr;
  logic [NPORTS*DW-1:0] wdata;
  logic [NPORTS-1:0]    ack;
  logic [NPORTS*DW-1:0] rdata;
  logic                 busy;

  modport master (
    output req, we, addr, wdata,
    input  ack, rdata, busy
  );

  modport slave (
    input  req, we, addr, wdata,
    output ack, rdata, busy
  );
endinterface

// File: rtl/sram_arbiter_ctrl.sv
// Multi-port arbiter/sequencer for an asynchronous SRAM.
// All SRAM pins come from registers, so we_n never glitches.
module sram_arbiter_ctrl #(
  parameter int AW          = 19,
  parameter int DW          = 8,
  parameter int NPORTS      = 2,
  parameter int WAIT_CYCLES = 1,
  parameter int RR_MODE     = 0
) (
  input  logic          clk,
  input  logic          power_on_reset_n,
  sram_arbiter_ctrl_if.slave bus,
  output logic [AW-1:0] sram_addr,
  inout  wire  [DW-1:0] sram_data,
  output logic          sram_we_n
);
  localparam int IW = (NPORTS > 1) ? $clog2(NPORTS) : 1;
  localparam logic [3:0] WAIT_LD = 4'(WAIT_CYCLES);
  localparam logic [IW-1:0] PTR_RST = IW'(NPORTS - 1);

  typedef enum logic [1:0] {
    IDLE,
    SETUP,
    ACCESS,
    RECOVER
  } state_e;

  state_e               state_q, state_d;
  logic [3:0]           cnt_q, cnt_d;
  logic [IW-1:0]        idx_q, idx_d;
  logic [IW-1:0]        ptr_q, ptr_d;
  logic                 wr_q, wr_d;
  logic [AW-1:0]        addr_q, addr_d;
  logic [DW-1:0]        wdat_q, wdat_d;
  logic                 oe_q, oe_d;
  logic                 we_n_q, we_n_d;
  logic [NPORTS-1:0]    ack_q, ack_d;
  logic [NPORTS*DW-1:0] rdata_q, rdata_d;
  logic [IW-1:0]        win;
  logic                 win_vld;

  // Fixed mode scans from port 0; RR mode from the port after ptr.
  always_comb begin : pick
    logic [IW-1:0] j;
    win     = '0;
    win_vld = 1'b0;
    j       = '0;
    for (int k = 0; k < NPORTS; k++) begin
      if (RR_MODE != 0)
        j = IW'((int'(ptr_q) + k + 1) % NPORTS);
      else
        j = IW'(k);
      if (!win_vld && bus.req[j]) begin
        win     = j;
        win_vld = 1'b1;
      end
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    idx_d   = idx_q;
    ptr_d   = ptr_q;
    wr_d    = wr_q;
    addr_d  = addr_q;
    wdat_d  = wdat_q;
    oe_d    = oe_q;
    we_n_d  = 1'b1;
    ack_d   = '0;
    rdata_d = rdata_q;
    unique case (state_q)
      IDLE: begin
        if (win_vld) begin
          state_d = SETUP;
          idx_d   = win;
          wr_d    = bus.we[win];
          oe_d    = bus.we[win];
          addr_d  = bus.addr[int'(win)*AW +: AW];
          wdat_d  = bus.wdata[int'(win)*DW +: DW];
        end
      end
      SETUP: begin
        state_d = ACCESS;
        cnt_d   = WAIT_LD;
        we_n_d  = ~wr_q;
      end
      ACCESS: begin
        if (cnt_q == 4'd0) begin
          state_d        = RECOVER;
          ack_d[idx_q]   = 1'b1;
          if (!wr_q)
            rdata_d[int'(idx_q)*DW +: DW] = sram_data;
          if (RR_MODE != 0)
            ptr_d = idx_q;
        end else begin
          cnt_d  = cnt_q - 4'd1;
          we_n_d = ~wr_q;
        end
      end
      RECOVER: begin
        // data stays driven here for hold after we_n rises
        state_d = IDLE;
        oe_d    = 1'b0;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!power_on_reset_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      idx_q   <= '0;
      ptr_q   <= PTR_RST;
      wr_q    <= 1'b0;
      addr_q  <= '0;
      wdat_q  <= '0;
      oe_q    <= 1'b0;
      we_n_q  <= 1'b1;
      ack_q   <= '0;
      rdata_q <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      idx_q   <= idx_d;
      ptr_q   <= ptr_d;
      wr_q    <= wr_d;
      addr_q  <= addr_d;
      wdat_q  <= wdat_d;
      oe_q    <= oe_d;
      we_n_q  <= we_n_d;
      ack_q   <= ack_d;
      rdata_q <= rdata_d;
    end
  end

  assign sram_addr = addr_q;
  assign sram_we_n = we_n_q;
  assign sram_data = oe_q ? wdat_q : {DW{1'bz}};
  assign bus.ack   = ack_q;
  assign bus.rdata = rdata_q;
  assign bus.busy  = (state_q != IDLE);
endmodule

// File: tb/tb_sram_arbiter_ctrl.sv
// Directed bench: four controller instances (fixed W=1, RR W=1,
// W=0, W=15) each with a small byte-wide SRAM model.
module tb_sram_arbiter_ctrl;
  localparam int NC = 4;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [1:0]  req   [NC];
  logic [1:0]  we    [NC];
  logic [37:0] addr  [NC];
  logic [15:0] wdata [NC];
  logic [1:0]  ack   [NC];
  logic [15:0] rdata [NC];
  logic        busy  [NC];
  logic [18:0] saddr [NC];
  logic        swe_n [NC];
  logic [7:0]  sdat  [NC];
  logic        soe   [NC];
  logic [7:0]  mem   [NC][256];
  logic        pw    [NC];
  logic [7:0]  pa    [NC];
  logic [7:0]  pd    [NC];
  bit          ini = 1'b0;

  int n_chk = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  for (genvar g = 0; g < NC; g++) begin : gi
    localparam int W = (g < 2) ? 1 : ((g == 2) ? 0 : 15);
    localparam int R = (g == 1) ? 1 : 0;
    sram_arbiter_ctrl_if #(.NPORTS(2), .AW(19), .DW(8)) ifc ();
    wire  [7:0]  sd;
    logic [18:0] sa;
    logic        swn;

    assign ifc.req   = req[g];
    assign ifc.we    = we[g];
    assign ifc.addr  = addr[g];
    assign ifc.wdata = wdata[g];
    assign ack[g]    = ifc.ack;
    assign rdata[g]  = ifc.rdata;
    assign busy[g]   = ifc.busy;
    assign saddr[g]  = sa;
    assign swe_n[g]  = swn;
    assign sdat[g]   = sd;
    assign sd = soe[g] ? mem[g][sa[7:0]] : 8'bz;

    sram_arbiter_ctrl #(
      .AW(19), .DW(8), .NPORTS(2),
      .WAIT_CYCLES(W), .RR_MODE(R)
    ) dut (
      .clk              (clk),
      .power_on_reset_n (rst_n),
      .bus              (ifc),
      .sram_addr        (sa),
      .sram_data        (sd),
      .sram_we_n        (swn)
    );
  end

  // SRAM model: a write lands on the rising we_n edge, unless that
  // edge is the one where the controller is being reset.
  always @(posedge clk) begin
    #1;
    if (!ini) begin
      for (int g = 0; g < NC; g++)
        for (int a = 0; a < 256; a++)
          mem[g][a] = 8'(a) ^ 8'h38;
      ini = 1'b1;
    end
    for (int g = 0; g < NC; g++) begin
      if (rst_n && swe_n[g] && !pw[g])
        mem[g][pa[g]] = pd[g];
      pw[g] = swe_n[g];
      pa[g] = saddr[g][7:0];
      pd[g] = sdat[g];
    end
  end

  task automatic xact(input int g, input int p, input bit w,
                      input logic [18:0] a, input logic [7:0] d,
                      output int lat, output int wel, output bit aok);
    int n;
    @(negedge clk);
    req[g][p] = 1'b1;
    we[g][p] = w;
    addr[g][p*19 +: 19] = a;
    wdata[g][p*8 +: 8] = d;
    lat = -1;
    wel = 0;
    aok = 1'b1;
    n = 0;
    while (lat < 0 && n < 40) begin
      @(negedge clk);
      n++;
      if (!swe_n[g]) wel++;
      if (busy[g] && saddr[g] !== a) aok = 1'b0;
      if (ack[g][p]) lat = n;
    end
    req[g][p] = 1'b0;
    we[g][p] = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    n_chk++;
    if (busy[0] !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_busy got %b want 0", busy[0]);
    end
    n_chk++;
    if (ack[0] !== 2'b00) begin
      n_fail++;
      $display("FAIL reset_ack got %b want 00", ack[0]);
    end
    n_chk++;
    if (rdata[0] !== 16'h0) begin
      n_fail++;
      $display("FAIL reset_rdata got %h want 0000", rdata[0]);
    end
    n_chk++;
    if (swe_n[0] !== 1'b1) begin
      n_fail++;
      $display("FAIL reset_we_n got %b want 1", swe_n[0]);
    end
    n_chk++;
    if (saddr[0] !== 19'h0) begin
      n_fail++;
      $display("FAIL reset_addr got %h want 0", saddr[0]);
    end
    rst_n = 1'b1;
  endtask

  task automatic test_single_read();
    int lat, wel;
    bit aok;
    soe[0] = 1'b1;
    xact(0, 0, 1'b0, 19'h15800, 8'h00, lat, wel, aok);
    n_chk++;
    if (lat !== 4) begin
      n_fail++;
      $display("FAIL rd_latency got %0d want 4", lat);
    end
    n_chk++;
    if (rdata[0][7:0] !== 8'h38) begin
      n_fail++;
      $display("FAIL rd_data got %h want 38", rdata[0][7:0]);
    end
    n_chk++;
    if (wel !== 0) begin
      n_fail++;
      $display("FAIL rd_we_low got %0d want 0", wel);
    end
    n_chk++;
    if (aok !== 1'b1) begin
      n_fail++;
      $display("FAIL rd_addr_stable got %b want 1", aok);
    end
  endtask

  task automatic test_write_read();
    int lat, wel;
    bit aok;
    soe[0] = 1'b0;
    xact(0, 1, 1'b1, 19'h00010, 8'hA5, lat, wel, aok);
    n_chk++;
    if (wel !== 2) begin
      n_fail++;
      $display("FAIL wr_we_low got %0d want 2", wel);
    end
    n_chk++;
    if (aok !== 1'b1) begin
      n_fail++;
      $display("FAIL wr_addr_stable got %b want 1", aok);
    end
    n_chk++;
    if (lat !== 4) begin
      n_fail++;
      $display("FAIL wr_latency got %0d want 4", lat);
    end
    n_chk++;
    if (rdata[0] !== 16'h0038) begin
      n_fail++;
      $display("FAIL wr_keeps_rdata got %h want 0038", rdata[0]);
    end
    soe[0] = 1'b1;
    xact(0, 1, 1'b0, 19'h00010, 8'h00, lat, wel, aok);
    n_chk++;
    if (rdata[0][15:8] !== 8'hA5) begin
      n_fail++;
      $display("FAIL rdback_p1 got %h want a5", rdata[0][15:8]);
    end
    n_chk++;
    if (rdata[0][7:0] !== 8'h38) begin
      n_fail++;
      $display("FAIL rdback_p0_kept got %h want 38", rdata[0][7:0]);
    end
  endtask

  task automatic test_fixed_prio();
    int t0, t1, n;
    bit both;
    soe[0] = 1'b1;
    @(negedge clk);
    req[0] = 2'b11;
    we[0] = 2'b00;
    addr[0] = {19'h00021, 19'h00020};
    t0 = -1;
    t1 = -1;
    both = 1'b0;
    n = 0;
    while ((t0 < 0 || t1 < 0) && n < 40) begin
      @(negedge clk);
      n++;
      if (ack[0] == 2'b11) both = 1'b1;
      if (ack[0][0] && t0 < 0) begin
        t0 = n;
        req[0][0] = 1'b0;
      end
      if (ack[0][1] && t1 < 0) begin
        t1 = n;
        req[0][1] = 1'b0;
      end
    end
    req[0] = 2'b00;
    n_chk++;
    if (t0 !== 4) begin
      n_fail++;
      $display("FAIL prio_p0_ack got %0d want 4", t0);
    end
    n_chk++;
    if (t1 !== 9) begin
      n_fail++;
      $display("FAIL prio_p1_ack got %0d want 9", t1);
    end
    n_chk++;
    if (both !== 1'b0) begin
      n_fail++;
      $display("FAIL prio_ack_onehot got %b want 0", both);
    end
    n_chk++;
    if (rdata[0] !== 16'h1918) begin
      n_fail++;
      $display("FAIL prio_rdata got %h want 1918", rdata[0]);
    end
  endtask

  task automatic test_round_robin();
    logic [3:0] seq;
    int cnt, n, first, last;
    soe[1] = 1'b1;
    @(negedge clk);
    req[1] = 2'b11;
    we[1] = 2'b00;
    addr[1] = {19'h00041, 19'h00040};
    seq = '0;
    cnt = 0;
    n = 0;
    first = -1;
    last = -1;
    while (cnt < 4 && n < 60) begin
      @(negedge clk);
      n++;
      if (ack[1] != 2'b00) begin
        seq[cnt] = ack[1][1];
        if (cnt == 0) first = n;
        last = n;
        cnt++;
      end
    end
    req[1] = 2'b00;
    n_chk++;
    if (seq !== 4'b1010 || cnt !== 4) begin
      n_fail++;
      $display("FAIL rr_order got %b (%0d acks) want 1010", seq, cnt);
    end
    n_chk++;
    if (last - first !== 15) begin
      n_fail++;
      $display("FAIL rr_span got %0d want 15", last - first);
    end
  endtask

  task automatic test_reset_mid_write();
    int lat, wel;
    bit aok;
    soe[0] = 1'b0;
    @(negedge clk);
    req[0][0] = 1'b1;
    we[0][0] = 1'b1;
    addr[0][18:0] = 19'h00030;
    wdata[0][7:0] = 8'h5A;
    repeat (2) @(negedge clk);
    n_chk++;
    if (swe_n[0] !== 1'b0) begin
      n_fail++;
      $display("FAIL mid_we_low got %b want 0", swe_n[0]);
    end
    rst_n = 1'b0;
    req[0] = 2'b00;
    we[0] = 2'b00;
    @(negedge clk);
    n_chk++;
    if (swe_n[0] !== 1'b1) begin
      n_fail++;
      $display("FAIL mid_we_rise got %b want 1", swe_n[0]);
    end
    n_chk++;
    if (busy[0] !== 1'b0) begin
      n_fail++;
      $display("FAIL mid_busy got %b want 0", busy[0]);
    end
    n_chk++;
    if (ack[0] !== 2'b00) begin
      n_fail++;
      $display("FAIL mid_ack got %b want 00", ack[0]);
    end
    rst_n = 1'b1;
    soe[0] = 1'b1;
    xact(0, 0, 1'b0, 19'h00030, 8'h00, lat, wel, aok);
    n_chk++;
    if (rdata[0][7:0] !== 8'h08) begin
      n_fail++;
      $display("FAIL mid_old_data got %h want 08", rdata[0][7:0]);
    end
  endtask

  task automatic test_cancel();
    int t1, n, a0, b;
    soe[0] = 1'b1;
    @(negedge clk);
    req[0][1] = 1'b1;
    we[0] = 2'b00;
    addr[0] = {19'h00051, 19'h00050};
    t1 = -1;
    a0 = 0;
    n = 0;
    while (t1 < 0 && n < 40) begin
      @(negedge clk);
      n++;
      if (n == 1) req[0][0] = 1'b1;
      if (n == 2) req[0][0] = 1'b0;
      if (ack[0][0]) a0++;
      if (ack[0][1]) t1 = n;
    end
    req[0] = 2'b00;
    b = 0;
    repeat (10) begin
      @(negedge clk);
      if (ack[0][0]) a0++;
      if (busy[0]) b++;
    end
    n_chk++;
    if (t1 !== 4) begin
      n_fail++;
      $display("FAIL cancel_p1_ack got %0d want 4", t1);
    end
    n_chk++;
    if (a0 !== 0) begin
      n_fail++;
      $display("FAIL cancel_p0_ack got %0d want 0", a0);
    end
    n_chk++;
    if (b !== 0) begin
      n_fail++;
      $display("FAIL cancel_busy got %0d want 0", b);
    end
  endtask

  task automatic test_wait_sweep();
    int lat, wel;
    bit aok;
    soe[2] = 1'b0;
    xact(2, 0, 1'b1, 19'h00060, 8'h3C, lat, wel, aok);
    n_chk++;
    if (wel !== 1) begin
      n_fail++;
      $display("FAIL w0_we_low got %0d want 1", wel);
    end
    n_chk++;
    if (lat !== 3) begin
      n_fail++;
      $display("FAIL w0_latency got %0d want 3", lat);
    end
    soe[2] = 1'b1;
    xact(2, 1, 1'b0, 19'h00060, 8'h00, lat, wel, aok);
    n_chk++;
    if (rdata[2][15:8] !== 8'h3C) begin
      n_fail++;
      $display("FAIL w0_rdback got %h want 3c", rdata[2][15:8]);
    end
    soe[3] = 1'b0;
    xact(3, 1, 1'b1, 19'h00070, 8'hC3, lat, wel, aok);
    n_chk++;
    if (wel !== 16) begin
      n_fail++;
      $display("FAIL w15_we_low got %0d want 16", wel);
    end
    n_chk++;
    if (lat !== 18) begin
      n_fail++;
      $display("FAIL w15_latency got %0d want 18", lat);
    end
    n_chk++;
    if (aok !== 1'b1) begin
      n_fail++;
      $display("FAIL w15_addr_stable got %b want 1", aok);
    end
    soe[3] = 1'b1;
    xact(3, 0, 1'b0, 19'h00070, 8'h00, lat, wel, aok);
    n_chk++;
    if (rdata[3][7:0] !== 8'hC3 || lat !== 18) begin
      n_fail++;
      $display("FAIL w15_rdback got %h/%0d want c3/18",
               rdata[3][7:0], lat);
    end
  endtask

  initial begin
    rst_n = 1'b0;
    for (int g = 0; g < NC; g++) begin
      req[g] = '0;
      we[g] = '0;
      addr[g] = '0;
      wdata[g] = '0;
      soe[g] = 1'b0;
      pw[g] = 1'b1;
      pa[g] = '0;
      pd[g] = '0;
    end
    test_reset();
    test_single_read();
    test_write_read();
    test_fixed_prio();
    test_round_robin();
    test_reset_mid_write();
    test_cancel();
    test_wait_sweep();
    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end
endmodule
